mb8_arbiter: RTL and testbench
==============================

// Module: mb8_arbiter
// PURPOSE
//  Shares the single-port 8-bit spram bus among NREQ bus masters (finder,
//  atoier, eforth, comma) in place of hand-muxing inside the outer interpreter.
//  Round-robin grant with ownership hold, optional lock, and a burst limit
//  against starvation. Routes the 1-cycle-latency read-data strobe back to
//  the master that issued the read.
// PARAMETERS
//  NREQ   4   number of requesters; index 0 = finder, 1 = atoi, 2 = exe, 3 = comma
//  ASZ    17  address width (128K)
//  MSZ    8   memory data width
//  MAXBST 16  cycles an unlocked owner may hold the bus while others wait
// PORTS
//  clk     in   1          clock
//  rst     in   1          synchronous, active-high reset
//  req     in   NREQ       bus request; held high for as long as ownership is wanted
//  lock    in   NREQ       owner lock; suppresses burst-limit preemption
//  we      in   NREQ       per-requester write enable
//  ai      in   NREQ*ASZ   per-requester address, packed [i*ASZ +: ASZ]
//  vi      in   NREQ*MSZ   per-requester write data
//  gnt     out  NREQ       one-hot grant (registered)
//  rvld    out  NREQ       one-hot strobe: read data valid on mem_vo for this requester
//  mem_we  out  1          to spram: write enable
//  mem_ai  out  ASZ        to spram: address
//  mem_vi  out  MSZ        to spram: write data
//  bsy     out  1          bus owned (|gnt)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): gnt=0, rvld=0, state ARB_IDLE, rr pointer=0,
//    burst cnt=0. Any read in flight is dropped: no rvld after reset.
//  - States (arb_sts): ARB_IDLE (no owner), ARB_OWN (owner = one-hot gnt).
//    IDLE -> OWN when any req is high: winner = first set req searching from
//    ptr upward, with wrap-around; gnt is registered, so it asserts 1 cycle
//    after req.
//    OWN -> OWN (same owner) while req[owner] is high and not preempted.
//    OWN -> handover when req[owner] falls: if another req is high, the next
//    winner (search from owner+1) is granted at that edge, so there is no idle
//    cycle; otherwise -> IDLE.
//    Preempt: when cnt reaches MAXBST-1, lock[owner]=0 and another req is
//    pending, gnt moves to the next winner at that edge. The preempted master
//    sees its gnt drop and must keep req high to regain the bus.
//  - ptr <= owner+1 (mod NREQ) on every grant change; a single requester may
//    therefore re-win immediately. cnt clears on a grant change and otherwise
//    increments, saturating at MAXBST-1.
//  - Bus mux is combinational from gnt: mem_we/ai/vi = we/ai/vi[owner]. When
//    idle: mem_we=0, mem_ai=0, mem_vi=0. A non-owner's we is never forwarded.
//  - Read tracking: a granted cycle with we=0 registers rid=owner. The next
//    cycle rvld[rid]=1 for exactly 1 cycle, even if the grant has since moved.
//    Writes never produce rvld.
//  - Simultaneous req edges: only round-robin order decides the winner.
//    Req and release in the same cycle by different masters resolve per the
//    handover rule.
//  - A req dropped while not granted is ignored; no grant is issued to it later.
//  - lock without req has no effect; ownership ends when req falls, whatever
//    lock is.
// STRUCTURE
//  - forthsuper package: typedef enum logic {ARB_IDLE, ARB_OWN} arb_sts;
//    localparam requester indices REQ_FDR=0, REQ_A2I=1, REQ_EXE=2, REQ_CMA=3.
//  - Sub-module rr_pick #(NREQ): combinational round-robin picker
//    (req, ptr -> one-hot win, any). Instantiated once.
//  - Top: 4-block FSM (state reg, next-state, output mux, registered
//    ptr/cnt/rid/rvld).
// TESTING
//  1. Single: req[1]=1 at t0, ai[1]='h100, we=0 -> gnt=4'b0010 at t1,
//     mem_ai='h100 at t1, rvld=4'b0010 at t2.
//  2. Contention: req=4'b1111 from IDLE, ptr=0, each master drops req after
//     2 cycles -> grant order 0,1,2,3 with no idle gaps.
//  3. Burst limit: req[0] held 40 cycles, lock=0, req[2] raised at cycle 3 ->
//     gnt moves to 2 after 16 owned cycles; with lock[0]=1, 0 keeps the bus
//     for all 40 cycles.
//  4. Write isolation: req[3] writes 'hA5 to 'h200 while req[0] is pending ->
//     mem_we=1 only in cycles with gnt[3]; no rvld produced.
//  5. Read across handover: owner 2 reads, then drops req -> gnt moves to 1
//     the next cycle, and rvld[2] (not rvld[1]) pulses that cycle.
//  6. Reset mid-burst: rst=1 while gnt[1]=1 and a read is in flight -> next
//     cycle gnt=0 and rvld=0; then req[0] and req[1] both high -> 0 wins
//     (ptr=0).

Source files
------------

// File: rtl/mb8_arbiter_pkg.sv
// Shared types and requester indices for the 8-bit spram bus arbiter.
package mb8_arbiter_pkg;

  typedef enum logic {ARB_IDLE, ARB_OWN} arb_sts;

  localparam int REQ_FDR = 0;
  localparam int REQ_A2I = 1;
  localparam int REQ_EXE = 2;
  localparam int REQ_CMA = 3;

endpackage

// File: rtl/mb8_arbiter_if.sv
// Requester-side bundle plus the muxed spram command bus driven by the arbiter.
interface mb8_arbiter_if #(
  parameter int NREQ = 4,
  parameter int ASZ  = 17,
  parameter int MSZ  = 8
);
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     lock;
  logic [NREQ-1:0]     we;
  logic [NREQ*ASZ-1:0] ai;
  logic [NREQ*MSZ-1:0] vi;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     rvld;
  logic                mem_we;
  logic [ASZ-1:0]      mem_ai;
  logic [MSZ-1:0]      mem_vi;
  logic                bsy;

  modport master (
    output req, lock, we, ai, vi,
    input  gnt, rvld, mem_we, mem_ai, mem_vi, bsy
  );

  modport slave (
    input  req, lock, we, ai, vi,
    output gnt, rvld, mem_we, mem_ai, mem_vi, bsy
  );
endinterface

// File: rtl/mb8_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req at or after ptr, with wrap.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]              req,
  input  logic [$clog2(NREQ)-1:0]      ptr,
  output logic [NREQ-1:0]              win,
  output logic                         any
);
  localparam int PW = $clog2(NREQ);

  always_comb begin
    int            idx;
    logic [PW-1:0] sel;
    win = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      sel = PW'(idx);
      if (!any && req[sel]) begin
        win[sel] = 1'b1;
        any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mb8_arbiter.sv
// Round-robin owner arbiter for the single-port 8-bit spram; registered one-hot grant,
// combinational bus mux, burst-limit preemption unless locked, read strobe 1 cycle after a read.
module mb8_arbiter
  import mb8_arbiter_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ASZ    = 17,
  parameter int MSZ    = 8,
  parameter int MAXBST = 16
) (
  input logic          clk,
  input logic          rst,
  mb8_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MAXBST);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAXBST - 1);

  arb_sts          sts, sts_nxt;
  logic [NREQ-1:0] gnt, gnt_nxt, rvld;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] cand, win;
  logic            any, own_req, own_lock, chg;
  logic            mem_we;
  logic [ASZ-1:0]  mem_ai;
  logic [MSZ-1:0]  mem_vi;

  // The owner is excluded so preemption and handover both pick someone else;
  // ptr already sits at owner+1 while owning.
  assign cand     = bus.req & ~gnt;
  assign own_req  = |(bus.req & gnt);
  assign own_lock = |(bus.lock & gnt);
  assign chg      = (gnt_nxt != gnt);

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (cand),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sts <= ARB_IDLE;
      gnt <= '0;
    end else begin
      sts <= sts_nxt;
      gnt <= gnt_nxt;
    end
  end

  always_comb begin
    sts_nxt = sts;
    gnt_nxt = gnt;
    unique case (sts)
      ARB_IDLE: begin
        if (any) begin
          sts_nxt = ARB_OWN;
          gnt_nxt = win;
        end
      end
      ARB_OWN: begin
        if (!own_req) begin
          if (any) begin
            gnt_nxt = win;
          end else begin
            sts_nxt = ARB_IDLE;
            gnt_nxt = '0;
          end
        end else if (cnt == CNT_MAX && !own_lock && any) begin
          gnt_nxt = win;
        end
      end
    endcase
  end

  always_comb begin
    mem_we = 1'b0;
    mem_ai = '0;
    mem_vi = '0;
    for (int i = 0; i < NREQ; i++) begin
      mem_we = mem_we | (bus.we[i] & gnt[i]);
      mem_ai = mem_ai | (bus.ai[i*ASZ +: ASZ] & {ASZ{gnt[i]}});
      mem_vi = mem_vi | (bus.vi[i*MSZ +: MSZ] & {MSZ{gnt[i]}});
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_nxt[i]) ptr_nxt = PW'((i + 1) % NREQ);
    end
  end

  // rvld follows the owner of the read cycle, not the current grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr  <= '0;
      cnt  <= '0;
      rvld <= '0;
    end else begin
      if (chg) begin
        cnt <= '0;
        if (|gnt_nxt) ptr <= ptr_nxt;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      rvld <= gnt & {NREQ{~mem_we}};
    end
  end

  assign bus.gnt    = gnt;
  assign bus.rvld   = rvld;
  assign bus.bsy    = |gnt;
  assign bus.mem_we = mem_we;
  assign bus.mem_ai = mem_ai;
  assign bus.mem_vi = mem_vi;
endmodule

// File: tb/tb_mb8_arbiter.sv
// Scoreboard bench: owner/pointer/burst reference model predicts every cycle's bus outputs.
module tb_mb8_arbiter;
  import mb8_arbiter_pkg::*;

  localparam int NREQ = 4, ASZ = 17, MSZ = 8, MAXBST = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mb8_arbiter_if #(.NREQ(NREQ), .ASZ(ASZ), .MSZ(MSZ)) bus ();
  mb8_arbiter #(.NREQ(NREQ), .ASZ(ASZ), .MSZ(MSZ), .MAXBST(MAXBST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] rvld;
    logic            mem_we;
    logic [ASZ-1:0]  mem_ai;
    logic [MSZ-1:0]  mem_vi;
    logic            bsy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  logic [NREQ-1:0] r_req, r_lock, r_we;
  logic [ASZ-1:0]  r_ai[NREQ];
  logic [MSZ-1:0]  r_vi[NREQ];
  logic            r_rst;

  // Reference model: owner index (-1 = idle), search start, owned-cycle count, pending read owner.
  int m_owner, m_ptr, m_cnt, m_rd;
  bit m_valid = 0;

  logic [NREQ-1:0] cur_gnt, cur_rvld;
  logic [ASZ-1:0]  cur_mai;
  logic            cur_mwe;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int search(int start, int excl);
    for (int k = 0; k < NREQ; k++) begin
      int j = (start + k) % NREQ;
      if (r_req[j] && j != excl) return j;
    end
    return -1;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    e = '0;
    if (m_owner >= 0) begin
      e.gnt[m_owner] = 1'b1;
      e.mem_we       = r_we[m_owner];
      e.mem_ai       = r_ai[m_owner];
      e.mem_vi       = r_vi[m_owner];
      e.bsy          = 1'b1;
    end
    if (m_rd >= 0) e.rvld[m_rd] = 1'b1;
    return e;
  endfunction

  task automatic model_step();
    int nxt, c;
    if (r_rst) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_rd = -1; m_valid = 1;
      return;
    end
    m_rd = (m_owner >= 0 && !r_we[m_owner]) ? m_owner : -1;
    nxt  = m_owner;
    if (m_owner < 0) begin
      nxt = search(m_ptr, -1);
    end else if (!r_req[m_owner]) begin
      nxt = search(m_owner + 1, m_owner);
    end else if (m_cnt == MAXBST - 1 && !r_lock[m_owner]) begin
      c = search(m_owner + 1, m_owner);
      if (c >= 0) nxt = c;
    end
    if (nxt != m_owner) begin
      m_cnt = 0;
      if (nxt >= 0) m_ptr = (nxt + 1) % NREQ;
    end else if (m_cnt < MAXBST - 1) begin
      m_cnt++;
    end
    m_owner = nxt;
  endtask

  // Drive one cycle of inputs just after the edge, queue its expected outputs, advance the model.
  task automatic cyc();
    rst      = r_rst;
    bus.req  = r_req;
    bus.lock = r_lock;
    bus.we   = r_we;
    for (int i = 0; i < NREQ; i++) begin
      bus.ai[i*ASZ +: ASZ] = r_ai[i];
      bus.vi[i*MSZ +: MSZ] = r_vi[i];
    end
    if (m_valid) sb.push_back(expect_now());
    #1;
    cur_gnt  = bus.gnt;
    cur_rvld = bus.rvld;
    cur_mai  = bus.mem_ai;
    cur_mwe  = bus.mem_we;
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic clear_inputs();
    r_req = '0; r_lock = '0; r_we = '0;
    for (int i = 0; i < NREQ; i++) begin
      r_ai[i] = '0;
      r_vi[i] = '0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    r_rst = 1'b1;
    cyc();
    r_rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("gnt",    32'(bus.gnt),    32'(mon_e.gnt));
      check("rvld",   32'(bus.rvld),   32'(mon_e.rvld));
      check("mem_we", 32'(bus.mem_we), 32'(mon_e.mem_we));
      check("mem_ai", 32'(bus.mem_ai), 32'(mon_e.mem_ai));
      check("mem_vi", 32'(bus.mem_vi), 32'(mon_e.mem_vi));
      check("bsy",    32'(bus.bsy),    32'(mon_e.bsy));
    end
  end

  initial begin
    logic [NREQ-1:0] exp_seq[8];
    int run, viol, rv3, wr;
    bit broke;
    logic [NREQ-1:0] after;

    rst = 1'b1;
    clear_inputs();
    r_rst = 1'b1;
    cyc();
    cyc();
    check("reset_gnt", 32'(cur_gnt), 32'h0);
    r_rst = 1'b0;

    // Single read by requester 1.
    r_req = 4'b0010; r_ai[REQ_A2I] = 17'h100;
    cyc();
    cyc();
    check("single_gnt", 32'(cur_gnt), 32'h2);
    check("single_ai",  32'(cur_mai), 32'h100);
    r_req = '0;
    cyc();
    check("single_rvld", 32'(cur_rvld), 32'h2);
    cyc(); cyc();

    // Contention: everyone requests, each drops after two owned cycles.
    do_reset();
    exp_seq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
    r_req = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < NREQ; i++)
        if (m_owner == i && m_cnt >= 1) r_req[i] = 1'b0;
      cyc();
      if (k > 0) check("rr_order", 32'(cur_gnt), 32'(exp_seq[k-1]));
    end
    cyc(); cyc();

    // Burst limit, unlocked then locked.
    for (int lk = 0; lk < 2; lk++) begin
      do_reset();
      r_lock = (lk == 1) ? 4'b0001 : 4'b0000;
      run = 0; broke = 0; after = '0;
      for (int k = 0; k < 48; k++) begin
        r_req[REQ_FDR] = (k < 40);
        r_req[REQ_EXE] = (k >= 3);
        cyc();
        if (!broke) begin
          if (cur_gnt == 4'b0001) run++;
          else if (run > 0) begin broke = 1; after = cur_gnt; end
        end
      end
      check(lk ? "burst_locked_len" : "burst_len", 32'(run), (lk == 1) ? 32'd40 : 32'(MAXBST));
      check("burst_next_owner", 32'(after), 32'h4);
      r_req = '0; r_lock = '0;
      cyc(); cyc();
    end

    // Write isolation: 3 writes while 0 reads.
    do_reset();
    r_req = 4'b1001; r_we = 4'b1000;
    r_ai[REQ_CMA] = 17'h200; r_vi[REQ_CMA] = 8'hA5; r_ai[REQ_FDR] = 17'h055;
    viol = 0; rv3 = 0; wr = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (cur_mwe && cur_gnt != 4'b1000) viol++;
      if (cur_rvld[REQ_CMA]) rv3++;
      if (cur_mwe) wr++;
    end
    check("wr_isolation", 32'(viol), 32'd0);
    check("wr_no_rvld",   32'(rv3),  32'd0);
    check("wr_cycles",    32'(wr),   32'(MAXBST));
    r_req = '0; r_we = '0;
    cyc(); cyc();

    // Read across handover from 2 to 1.
    do_reset();
    r_req = 4'b0100; cyc();
    r_req = 4'b0110; cyc(); cyc();
    r_req = 4'b0010; cyc();
    cyc();
    check("handover_gnt",  32'(cur_gnt),  32'h2);
    check("handover_rvld", 32'(cur_rvld), 32'h4);
    r_req = '0;
    cyc(); cyc();

    // Reset while 1 owns the bus with a read in flight.
    do_reset();
    r_req = 4'b0010; cyc(); cyc();
    r_rst = 1'b1; cyc();
    r_rst = 1'b0; r_req = 4'b0011; cyc();
    check("rst_mid_gnt",  32'(cur_gnt),  32'h0);
    check("rst_mid_rvld", 32'(cur_rvld), 32'h0);
    cyc();
    check("rst_then_win", 32'(cur_gnt), 32'h1);
    r_req = '0;
    cyc(); cyc();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (r_req[i]) begin
          if ($urandom_range(7) == 0) r_req[i] = 1'b0;
        end else if ($urandom_range(5) == 0) begin
          r_req[i] = 1'b1;
        end
        if ($urandom_range(19) == 0) r_lock[i] = ~r_lock[i];
        r_we[i] = 1'($urandom_range(1));
        r_ai[i] = ASZ'($urandom);
        r_vi[i] = MSZ'($urandom);
      end
      r_rst = ($urandom_range(299) == 0);
      cyc();
    end
    r_rst = 1'b0;
    clear_inputs();
    cyc(); cyc();
    @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
